// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter steering N_REQ producers onto one channel via a 2:1 mux tree.
// Optional stall watchdog enabled by defining RR_MUX_ARB_WATCHDOG_EN.
module rr_mux_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [N_REQ-1:0]         grant,
`ifdef RR_MUX_ARB_WATCHDOG_EN
    output logic                     timeout,
`endif
    output logic                     busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int P  = 1 << PW;

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("rr_mux_arbiter: illegal parameter value");
    end

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t              r_state, w_state_nxt;
    logic [N_REQ-1:0]    r_grant, w_grant_nxt;
    logic [PW-1:0]       r_ptr, w_ptr_nxt;
    logic [PW-1:0]       w_gidx, w_gidx_inc, w_arb_idx;
    logic                w_any, w_locked, w_xfer, w_done, w_to;
    logic [P*WIDTH-1:0]  w_pad;
    logic [WIDTH-1:0]    w_node [P];

    assign w_locked = (r_state == S_LOCKED);

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (r_grant[i]) w_gidx = PW'(i);
    end

    assign w_gidx_inc = (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + PW'(1);

    // Descending scan so the requester closest to r_ptr overwrites the rest.
    always_comb begin
        w_any     = 1'b0;
        w_arb_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_any     = 1'b1;
                w_arb_idx = PW'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    // Binary mux tree, folded in place: each level halves the live nodes.
    assign w_pad = (P*WIDTH)'(req_data);
    always_comb begin
        for (int i = 0; i < P; i++)
            w_node[i] = w_pad[i*WIDTH +: WIDTH];
        for (int l = 0; l < PW; l++)
            for (int i = 0; i < P/2; i++)
                if (i < (P >> (l + 1)))
                    w_node[i] = w_gidx[l] ? w_node[2*i+1] : w_node[2*i];
    end

    // Only the registered grant gates the channel, so idle cycles output zeros.
    assign out_valid = |(req_valid & r_grant);
    assign out_last  = |(req_last & r_grant);
    assign out_data  = w_locked ? w_node[0] : '0;
    assign req_ready = r_grant & {N_REQ{out_ready}};
    assign grant     = r_grant;
    assign busy      = w_locked;

    assign w_xfer = out_valid & out_ready;
    assign w_done = w_xfer & out_last;

`ifdef RR_MUX_ARB_WATCHDOG_EN
    logic [7:0] r_stall, w_stall_nxt;
    logic       r_timeout;

    assign w_to        = w_locked && !w_xfer && (r_stall == 8'(TIMEOUT - 1));
    assign w_stall_nxt = (!w_locked || w_xfer || w_to) ? 8'd0 : r_stall + 8'd1;
    assign timeout     = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall   <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_stall   <= w_stall_nxt;
            r_timeout <= w_to;
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_LOCKED;
                    w_grant_nxt = N_REQ'(1) << w_arb_idx;
                end
            end
            S_LOCKED: begin
                if (w_done || w_to) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_gidx_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule
